// File: rtl/aes_package.sv
// Shared types and constants for the AES job scheduler and its arbiter.
package aes_package;

  typedef enum logic [1:0] {
    SCHED_IDLE,
    SCHED_ISSUE,
    SCHED_WAIT,
    SCHED_DONE
  } aes_sched_state_t;

  localparam int AES_BLK_BYTES = 16;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above i_rr_ptr, wrapping.
module aes_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_rr_ptr,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [$clog2(N_REQ)-1:0] o_index,
  output logic                     o_valid
);

  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0] w_idx;
  logic            w_found;

  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    o_gnt   = '0;
    o_index = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = ID_W'((32'(i_rr_ptr) + 32'(i)) % 32'(N_REQ));
      if (!w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_index      = w_idx;
        o_gnt[w_idx] = 1'b1;
      end
    end
    o_valid = w_found;
  end

endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one AES block engine between N_REQ requesters: round-robin grant,
// per-block start/done sequencing with address advance, watchdog and error reporting.
module aes_job_scheduler
  import aes_package::*;
#(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 16,
  parameter int BLK_BYTES = AES_BLK_BYTES,
  parameter int TIMEOUT   = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*ADDR_W-1:0]   src_addr_i,
  input  logic [N_REQ*ADDR_W-1:0]   dst_addr_i,
  input  logic [N_REQ*CNT_W-1:0]    nblk_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [N_REQ-1:0]          done_o,
  output logic [N_REQ-1:0]          err_o,
  output logic                      eng_start_o,
  output logic [ADDR_W-1:0]         eng_src_addr_o,
  output logic [ADDR_W-1:0]         eng_dst_addr_o,
  input  logic                      eng_ready_i,
  input  logic                      eng_done_i,
  output logic                      busy_o,
  output logic [$clog2(N_REQ)-1:0]  cur_id_o
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [WD_W-1:0]   WD_ONE   = WD_W'(1);
  localparam logic [WD_W-1:0]   WD_MAX   = '1;
  localparam logic [WD_W-1:0]   WD_LIM   = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(BLK_BYTES);
  localparam logic [ID_W-1:0]   ID_ONE   = ID_W'(1);
  localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(N_REQ - 1);

  aes_sched_state_t  r_state, w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [ID_W-1:0]   r_id, w_id_nxt;
  logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
  logic [ADDR_W-1:0] r_src, w_src_nxt;
  logic [ADDR_W-1:0] r_dst, w_dst_nxt;
  logic [CNT_W-1:0]  r_nblk, w_nblk_nxt;
  logic [CNT_W-1:0]  r_blk_cnt, w_blk_cnt_nxt;
  logic [WD_W-1:0]   r_wd_cnt, w_wd_cnt_nxt;
  logic              r_err, w_err_nxt;

  logic [N_REQ-1:0]  w_arb_gnt;
  logic [ID_W-1:0]   w_arb_idx;
  logic              w_arb_valid;
  logic [ADDR_W-1:0] w_sel_src;
  logic [ADDR_W-1:0] w_sel_dst;
  logic [CNT_W-1:0]  w_sel_nblk;
  logic [WD_W-1:0]   w_wd_inc;

  aes_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req    (req_i),
    .i_rr_ptr (r_rr_ptr),
    .o_gnt    (w_arb_gnt),
    .o_index  (w_arb_idx),
    .o_valid  (w_arb_valid)
  );

  assign w_sel_src  = src_addr_i[w_arb_idx*ADDR_W +: ADDR_W];
  assign w_sel_dst  = dst_addr_i[w_arb_idx*ADDR_W +: ADDR_W];
  assign w_sel_nblk = nblk_i[w_arb_idx*CNT_W +: CNT_W];
  assign w_wd_inc   = (r_wd_cnt == WD_MAX) ? r_wd_cnt : r_wd_cnt + WD_ONE;

  always_comb begin
    w_state_nxt   = r_state;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_id_nxt      = r_id;
    w_gnt_nxt     = r_gnt;
    w_src_nxt     = r_src;
    w_dst_nxt     = r_dst;
    w_nblk_nxt    = r_nblk;
    w_blk_cnt_nxt = r_blk_cnt;
    w_wd_cnt_nxt  = r_wd_cnt;
    w_err_nxt     = r_err;
    eng_start_o   = 1'b0;

    case (r_state)
      SCHED_IDLE: begin
        if (w_arb_valid) begin
          w_id_nxt      = w_arb_idx;
          w_gnt_nxt     = w_arb_gnt;
          w_src_nxt     = w_sel_src;
          w_dst_nxt     = w_sel_dst;
          w_nblk_nxt    = w_sel_nblk;
          w_blk_cnt_nxt = '0;
          w_wd_cnt_nxt  = '0;
          if (w_sel_nblk == '0) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = SCHED_DONE;
          end else begin
            w_state_nxt = SCHED_ISSUE;
          end
        end
      end
      SCHED_ISSUE: begin
        if (eng_ready_i) begin
          eng_start_o = 1'b1;
          w_state_nxt = SCHED_WAIT;
        end
      end
      SCHED_WAIT: begin
        if (eng_done_i) begin
          if (r_blk_cnt == (r_nblk - CNT_ONE)) begin
            w_state_nxt = SCHED_DONE;
          end else begin
            w_blk_cnt_nxt = r_blk_cnt + CNT_ONE;
            w_src_nxt     = r_src + ADDR_INC;
            w_dst_nxt     = r_dst + ADDR_INC;
            w_wd_cnt_nxt  = '0;
            w_state_nxt   = SCHED_ISSUE;
          end
        end else begin
          w_wd_cnt_nxt = w_wd_inc;
          // Compare the incremented count so the abort lands TIMEOUT cycles after start.
          if ((TIMEOUT != 0) && (w_wd_inc >= WD_LIM)) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = SCHED_DONE;
          end
        end
      end
      SCHED_DONE: begin
        w_rr_ptr_nxt = (r_id == ID_LAST) ? '0 : r_id + ID_ONE;
        w_err_nxt    = 1'b0;
        w_gnt_nxt    = '0;
        w_state_nxt  = SCHED_IDLE;
      end
      default: w_state_nxt = SCHED_IDLE;
    endcase

    if (clear) begin
      w_state_nxt   = SCHED_IDLE;
      w_rr_ptr_nxt  = '0;
      w_id_nxt      = '0;
      w_gnt_nxt     = '0;
      w_src_nxt     = '0;
      w_dst_nxt     = '0;
      w_nblk_nxt    = '0;
      w_blk_cnt_nxt = '0;
      w_wd_cnt_nxt  = '0;
      w_err_nxt     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= SCHED_IDLE;
      r_rr_ptr  <= '0;
      r_id      <= '0;
      r_gnt     <= '0;
      r_src     <= '0;
      r_dst     <= '0;
      r_nblk    <= '0;
      r_blk_cnt <= '0;
      r_wd_cnt  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_id      <= w_id_nxt;
      r_gnt     <= w_gnt_nxt;
      r_src     <= w_src_nxt;
      r_dst     <= w_dst_nxt;
      r_nblk    <= w_nblk_nxt;
      r_blk_cnt <= w_blk_cnt_nxt;
      r_wd_cnt  <= w_wd_cnt_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign busy_o         = (r_state != SCHED_IDLE);
  assign gnt_o          = r_gnt;
  assign done_o         = (r_state == SCHED_DONE) ? r_gnt : '0;
  assign err_o          = (r_state == SCHED_DONE && r_err) ? r_gnt : '0;
  assign cur_id_o       = r_id;
  assign eng_src_addr_o = r_src;
  assign eng_dst_addr_o = r_dst;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Directed bench for aes_job_scheduler: stimulus pushes expected engine starts and
// job completions into queues; a monitor pops and compares as the DUT produces them.
module tb_aes_job_scheduler;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int CW = 16;
  localparam int TO = 16;

  logic            clk;
  logic            reset;
  logic            clear;
  logic [N-1:0]    req_i;
  logic [N*AW-1:0] src_addr_i;
  logic [N*AW-1:0] dst_addr_i;
  logic [N*CW-1:0] nblk_i;
  logic [N-1:0]    gnt_o;
  logic [N-1:0]    done_o;
  logic [N-1:0]    err_o;
  logic            eng_start_o;
  logic [AW-1:0]   eng_src_addr_o;
  logic [AW-1:0]   eng_dst_addr_o;
  logic            eng_ready_i;
  logic            eng_done_i;
  logic            busy_o;
  logic [1:0]      cur_id_o;

  aes_job_scheduler #(
    .N_REQ(N), .ADDR_W(AW), .CNT_W(CW), .BLK_BYTES(16), .TIMEOUT(TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .clear          (clear),
    .req_i          (req_i),
    .src_addr_i     (src_addr_i),
    .dst_addr_i     (dst_addr_i),
    .nblk_i         (nblk_i),
    .gnt_o          (gnt_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .eng_start_o    (eng_start_o),
    .eng_src_addr_o (eng_src_addr_o),
    .eng_dst_addr_o (eng_dst_addr_o),
    .eng_ready_i    (eng_ready_i),
    .eng_done_i     (eng_done_i),
    .busy_o         (busy_o),
    .cur_id_o       (cur_id_o)
  );

  // ---------------- clock / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_time_limit: simulation did not complete within bound");
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_start_q[$];
  logic [7:0]  exp_done_q[$];
  int n_cmp     = 0;
  int n_fail    = 0;
  int n_starts  = 0;
  int n_done    = 0;
  int start_cyc = 0;
  int done_cyc  = 0;
  int eng_k     = 8;
  bit eng_en    = 1'b1;
  int gen       = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input int id, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] nb);
    src_addr_i[id*AW +: AW] = s;
    dst_addr_i[id*AW +: AW] = d;
    nblk_i[id*CW +: CW]     = nb;
  endtask

  task automatic push_start(input logic [31:0] s, input logic [31:0] d);
    exp_start_q.push_back({s, d});
  endtask

  task automatic push_done(input logic [3:0] e, input logic [3:0] d);
    exp_done_q.push_back({e, d});
  endtask

  task automatic wait_gnt(input int id);
    int t = 0;
    while (!gnt_o[id] && t < 100) begin
      tick(1);
      t++;
    end
    chk($sformatf("grant_req%0d", id), 64'(gnt_o[id]), 64'd1);
  endtask

  task automatic start_job(input int id);
    req_i[id] = 1'b1;
    wait_gnt(id);
    req_i[id] = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (n_done < target && t < 300) begin
      tick(1);
      t++;
    end
    chk("done_count", 64'(n_done), 64'(target));
  endtask

  // ---------------- monitor ----------------
  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("gnt_onehot0", 64'($onehot0(gnt_o)), 64'd1);
        if (eng_start_o) begin
          n_starts++;
          start_cyc = cyc;
          if (exp_start_q.size() == 0)
            chk("unexpected_start_qdepth", 64'(exp_start_q.size()), 64'd1);
          else
            chk("start_src_dst", {eng_src_addr_o, eng_dst_addr_o}, exp_start_q.pop_front());
        end
        if (done_o != '0) begin
          n_done++;
          done_cyc = cyc;
          if (exp_done_q.size() == 0) begin
            chk("unexpected_done_qdepth", 64'(exp_done_q.size()), 64'd1);
          end else begin
            e = exp_done_q.pop_front();
            chk("err_done", 64'({err_o, done_o}), 64'(e));
            chk("gnt_at_done", 64'(gnt_o), 64'(e[3:0]));
          end
        end
      end
    end
  endtask

  // ---------------- engine model ----------------
  task automatic engine();
    int g;
    forever begin
      @(negedge clk);
      if (!reset && eng_start_o && eng_en) begin
        g = gen;
        repeat (eng_k) @(posedge clk);
        #1;
        if (g == gen && eng_en) begin
          eng_done_i = 1'b1;
          @(posedge clk);
          #1;
          eng_done_i = 1'b0;
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t_req;
    int s0;
    int d0;
    int t;
    reset       = 1'b1;
    clear       = 1'b0;
    req_i       = '0;
    src_addr_i  = '0;
    dst_addr_i  = '0;
    nblk_i      = '0;
    eng_ready_i = 1'b1;
    eng_done_i  = 1'b0;

    fork
      monitor();
      engine();
    join_none

    tick(3);
    chk("reset_ctrl_outputs",
        64'({gnt_o, done_o, err_o, eng_start_o, busy_o, cur_id_o}), 64'd0);
    chk("reset_addr_outputs", {eng_src_addr_o, eng_dst_addr_o}, 64'd0);
    reset = 1'b0;
    tick(2);

    // single 3-block job
    eng_k = 8;
    set_desc(0, 32'h1000, 32'h2000, 16'd3);
    push_start(32'h1000, 32'h2000);
    push_start(32'h1010, 32'h2010);
    push_start(32'h1020, 32'h2020);
    push_done(4'b0000, 4'b0001);
    start_job(0);
    wait_done(1);
    tick(2);

    // minimum-latency single block job
    set_desc(1, 32'h3000, 32'h4000, 16'd1);
    push_start(32'h3000, 32'h4000);
    push_done(4'b0000, 4'b0010);
    t_req = cyc;
    start_job(1);
    wait_done(2);
    chk("start_latency", 64'(start_cyc), 64'(t_req + 1));
    chk("done_latency", 64'(done_cyc), 64'(t_req + 10));
    tick(2);

    // soft clear resets rr pointer, then round-robin over all requesters
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clear_busy", 64'(busy_o), 64'd0);
    eng_k = 3;
    for (int i = 0; i < N; i++)
      set_desc(i, 32'h0001_0000 + 32'(i * 256), 32'h0002_0000 + 32'(i * 256), 16'd1);
    for (int j = 0; j < 5; j++) begin
      push_start(32'h0001_0000 + 32'((j % 4) * 256), 32'h0002_0000 + 32'((j % 4) * 256));
      push_done(4'b0000, 4'(1 << (j % 4)));
    end
    req_i = 4'b1111;
    wait_done(6);
    wait_gnt(0);
    req_i = '0;
    wait_done(7);
    tick(2);

    // engine backpressure: start only when ready rises, watchdog idle meanwhile
    eng_k = 8;
    eng_ready_i = 1'b0;
    set_desc(2, 32'h5000, 32'h6000, 16'd1);
    push_start(32'h5000, 32'h6000);
    push_done(4'b0000, 4'b0100);
    start_job(2);
    s0 = n_starts;
    tick(20);
    chk("no_start_while_not_ready", 64'(n_starts), 64'(s0));
    chk("start_low_while_not_ready", 64'(eng_start_o), 64'd0);
    eng_ready_i = 1'b1;
    @(negedge clk);
    chk("start_on_ready_rise", 64'(eng_start_o), 64'd1);
    tick(1);
    wait_done(8);
    tick(2);

    // watchdog timeout, then requester 1 served
    eng_en = 1'b0;
    set_desc(2, 32'h7000, 32'h8000, 16'd1);
    push_start(32'h7000, 32'h8000);
    push_done(4'b0100, 4'b0100);
    start_job(2);
    wait_done(9);
    chk("timeout_delay", 64'(done_cyc - start_cyc), 64'(TO));
    chk("idle_after_timeout", 64'(busy_o), 64'd0);
    eng_en = 1'b1;
    set_desc(1, 32'h9000, 32'hA000, 16'd2);
    push_start(32'h9000, 32'hA000);
    push_start(32'h9010, 32'hA010);
    push_done(4'b0000, 4'b0010);
    start_job(1);
    wait_done(10);
    tick(2);

    // nblk = 0 reports error with no engine start
    set_desc(3, 32'hB000, 32'hC000, 16'd0);
    push_done(4'b1000, 4'b1000);
    s0 = n_starts;
    start_job(3);
    wait_done(11);
    chk("no_start_for_nblk0", 64'(n_starts), 64'(s0));
    tick(2);

    // address wrap
    set_desc(1, 32'hFFFF_FFF0, 32'h0000_1000, 16'd2);
    push_start(32'hFFFF_FFF0, 32'h0000_1000);
    push_start(32'h0000_0000, 32'h0000_1010);
    push_done(4'b0000, 4'b0010);
    start_job(1);
    wait_done(12);
    tick(2);

    // async reset during block 2 of 4
    set_desc(1, 32'hD000, 32'hE000, 16'd4);
    for (int b = 0; b < 4; b++)
      push_start(32'hD000 + 32'(b * 16), 32'hE000 + 32'(b * 16));
    push_done(4'b0000, 4'b0010);
    s0 = n_starts;
    start_job(1);
    t = 0;
    while (n_starts < s0 + 2 && t < 100) begin
      tick(1);
      t++;
    end
    chk("second_block_started", 64'(n_starts), 64'(s0 + 2));
    tick(3);
    #2;
    reset = 1'b1;
    gen++;
    #1;
    chk("async_reset_ctrl",
        64'({gnt_o, done_o, err_o, eng_start_o, busy_o, cur_id_o}), 64'd0);
    chk("async_reset_addr", {eng_src_addr_o, eng_dst_addr_o}, 64'd0);
    exp_start_q.delete();
    exp_done_q.delete();
    d0 = n_done;
    tick(2);
    reset = 1'b0;
    tick(12);
    chk("no_done_after_abort", 64'(n_done), 64'(d0));
    set_desc(0, 32'hF000, 32'hF800, 16'd1);
    set_desc(2, 32'h1111_0000, 32'h2222_0000, 16'd1);
    push_start(32'hF000, 32'hF800);
    push_done(4'b0000, 4'b0001);
    req_i = 4'b0101;
    wait_gnt(0);
    req_i = '0;
    wait_done(d0 + 1);
    tick(5);

    chk("start_queue_drained", 64'(exp_start_q.size()), 64'd0);
    chk("done_queue_drained", 64'(exp_done_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_job_scheduler.md
Name: aes_job_scheduler

Overview:
- Shares one AES engine (with its plaintext source / ciphertext sink streamers) between N_REQ requesters.
- Arbitrates round-robin and latches the winner's job descriptor: source address, destination address and block count.
- Sequences the engine one 128-bit block at a time, advancing both addresses per block, and reports completion, timeout or error per requester.
- Sits between the requester-side control logic and the engine FSM's start/done interface.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, address width
- CNT_W, 16, block-count width
- BLK_BYTES, 16, address increment per block
- TIMEOUT, 1024, max cycles in WAIT before abort (0 disables the watchdog)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- clear  in  1  synchronous soft clear, same effect as reset
- req_i  in  N_REQ  per-requester job request, level
- src_addr_i  in  N_REQ*ADDR_W  per-requester source base, packed, requester 0 in LSBs
- dst_addr_i  in  N_REQ*ADDR_W  per-requester destination base, packed
- nblk_i  in  N_REQ*CNT_W  per-requester block count, packed
- gnt_o  out  N_REQ  one-hot grant, held for the whole job
- done_o  out  N_REQ  one-cycle job-complete pulse
- err_o  out  N_REQ  one-cycle error pulse, coincident with done_o
- eng_start_o  out  1  one-cycle engine start
- eng_src_addr_o  out  ADDR_W  current block source address
- eng_dst_addr_o  out  ADDR_W  current block destination address
- eng_ready_i  in  1  engine idle, able to accept start
- eng_done_i  in  1  one-cycle engine block-done
- busy_o  out  1  state != IDLE
- cur_id_o  out  $clog2(N_REQ)  granted requester index

Behaviour:
- Reset/clear values: state IDLE; all outputs 0; rr_ptr 0; counters and addresses 0.
  - clear mid-job aborts silently: no done_o, no err_o.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req_i is set, pick the first set bit searching from rr_ptr upward, wrapping modulo N_REQ.
  - Latch that requester's src, dst and nblk, plus its id.
  - blk_cnt=0, wd_cnt=0.
  - If the latched nblk == 0 go to DONE with the error flag set; otherwise go to ISSUE.
  - gnt_o and cur_id_o are valid from the cycle after the request is sampled, until the cycle after DONE.
- ISSUE:
  - eng_start_o = eng_ready_i, combinational from the state.
  - If eng_ready_i: go to WAIT.
  - Else: stay in ISSUE; the watchdog does not run here.
  - eng_src_addr_o / eng_dst_addr_o are driven from the address registers at all times.
- WAIT:
  - On eng_done_i:
    - If blk_cnt == nblk-1: go to DONE.
    - Else: blk_cnt++, src += BLK_BYTES, dst += BLK_BYTES (wrap modulo 2^ADDR_W), wd_cnt=0, go to ISSUE.
  - Else wd_cnt++. If TIMEOUT != 0 and wd_cnt == TIMEOUT-1: set the error flag and go to DONE.
- DONE:
  - done_o[id]=1 for one cycle; err_o[id]=error flag.
  - rr_ptr = (id+1) mod N_REQ.
  - Clear the error flag; go to IDLE.
- Minimum job latency for nblk=1 with ready engine and done after k cycles: req sampled at t; start at t+1; done_o at t+k+2.
- eng_done_i outside WAIT is ignored.
- Descriptor inputs and req_i changes after the sample cycle are ignored until the next IDLE.
  - Deasserting req mid-job does not cancel the job.
- A requester holding req_i through done_o gets the lowest priority in the next arbitration.
- At least one idle cycle between jobs (DONE→IDLE).
- Width rules:
  - blk_cnt and nblk are unsigned CNT_W; the maximum nblk of 2^CNT_W-1 is legal.
  - wd_cnt is $clog2(TIMEOUT+1) bits and saturates.

Decomposition:
- Shared package aes_package gets:
  - aes_sched_state_t enum {SCHED_IDLE, SCHED_ISSUE, SCHED_WAIT, SCHED_DONE};
  - AES_BLK_BYTES = 16 constant.
- Natural sub-module: aes_rr_arbiter.
  - Parameter N_REQ.
  - Inputs req, rr_ptr; outputs one-hot gnt, index, valid.
  - Purely combinational.

Test Plan:
- Single job: req_i=0001, src=0x1000, dst=0x2000, nblk=3, engine done 8 cycles after each start.
  - Expect three eng_start_o pulses with src 0x1000/0x1010/0x1020 and dst 0x2000/0x2010/0x2020.
  - Expect done_o=0001 once and err_o=0.
- Round-robin: req_i=1111 held continuously, nblk=1 each.
  - Grant order 0,1,2,3,0.
  - gnt_o always one-hot; never two jobs overlapping.
- Engine backpressure: eng_ready_i low for 20 cycles after grant.
  - eng_start_o stays low; asserts exactly in the cycle ready rises.
  - No timeout (watchdog idle in ISSUE).
- Timeout: TIMEOUT=16, eng_done_i never arrives.
  - done_o and err_o pulse together 16 cycles after start; state returns to IDLE.
  - A next req on requester 1 is then served.
- Zero/boundary: nblk=0 → done_o+err_o with no eng_start_o.
  - src=0xFFFFFFF0, nblk=2 → second block src=0x00000000.
- Reset/clear mid-job: assert reset (async) during WAIT of block 2 of 4.
  - All outputs 0 immediately; no done_o.
  - After release, a fresh request restarts at block 0 with rr_ptr=0.
